// File: rtl/mem_copy_pkg.sv
// ============================================================================
// mem_copy_pkg : shared types and widths for the memory copy/fill engine
// Revision 1.0
// ============================================================================
`default_nettype none

package mem_copy_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic {
    COPY = 1'b0,
    FILL = 1'b1
  } mode_t;
endpackage

`default_nettype wire

// File: rtl/mcp_addr_step.sv
// ============================================================================
// mcp_addr_step : loadable 8-bit address register stepping +1/-1, modulo 256
// Revision 1.0
// ============================================================================
`default_nettype none

module mcp_addr_step
  import mem_copy_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_addr,
  input  logic              i_step,
  input  logic              i_down,
  output logic [ADDR_W-1:0] o_addr
);

  localparam logic [ADDR_W-1:0] C_ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] r_addr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr <= '0;
    end else if (i_load) begin
      r_addr <= i_load_addr;
    end else if (i_step) begin
      r_addr <= i_down ? (r_addr - C_ONE) : (r_addr + C_ONE);
    end
  end

  assign o_addr = r_addr;

endmodule

`default_nettype wire

// File: rtl/mem_copy_engine.sv
// ============================================================================
// mem_copy_engine : byte COPY/FILL engine driving a single 8-bit memory port
// Revision 1.0
// ============================================================================
`default_nettype none

module mem_copy_engine
  import mem_copy_pkg::*;
(
  input  logic              CLK,
  input  logic              ResetN,
  input  logic              Start,
  input  logic              Mode,
  input  logic              Descend,
  input  logic [ADDR_W-1:0] SrcAddr,
  input  logic [ADDR_W-1:0] DstAddr,
  input  logic [ADDR_W-1:0] Length,
  input  logic [DATA_W-1:0] FillValue,
  output logic [ADDR_W-1:0] DataAddress,
  output logic              ReadMem,
  output logic              WriteMem,
  output logic [DATA_W-1:0] DataIn,
  input  logic [DATA_W-1:0] DataOut,
  output logic              Busy,
  output logic              Done
);

  localparam logic [ADDR_W-1:0] C_LEN_ONE = ADDR_W'(1);

  state_t            r_state;
  mode_t             r_mode;
  logic              r_desc;
  logic [ADDR_W-1:0] r_rem;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_fill;
  logic              r_read_mem;
  logic              r_write_mem;
  logic              r_busy;
  logic              r_done;

  logic              w_accept;
  logic              w_step;
  logic [ADDR_W-1:0] w_src;
  logic [ADDR_W-1:0] w_dst;

  assign w_accept = (r_state == IDLE) && Start;
  assign w_step   = (r_state == WRITE);

  mcp_addr_step u_src_step (
    .clk         (CLK),
    .rst_n       (ResetN),
    .i_load      (w_accept),
    .i_load_addr (SrcAddr),
    .i_step      (w_step),
    .i_down      (r_desc),
    .o_addr      (w_src)
  );

  mcp_addr_step u_dst_step (
    .clk         (CLK),
    .rst_n       (ResetN),
    .i_load      (w_accept),
    .i_load_addr (DstAddr),
    .i_step      (w_step),
    .i_down      (r_desc),
    .o_addr      (w_dst)
  );

  always_ff @(posedge CLK) begin
    if (!ResetN) begin
      r_state     <= IDLE;
      r_mode      <= COPY;
      r_desc      <= 1'b0;
      r_rem       <= '0;
      r_data      <= '0;
      r_fill      <= '0;
      r_read_mem  <= 1'b0;
      r_write_mem <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (Start) begin
            r_mode <= mode_t'(Mode);
            r_desc <= Descend;
            r_rem  <= Length;
            r_fill <= FillValue;
            if (Length == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else if (mode_t'(Mode) == COPY) begin
              r_state    <= READ;
              r_busy     <= 1'b1;
              r_read_mem <= 1'b1;
            end else begin
              r_state     <= WRITE;
              r_busy      <= 1'b1;
              r_write_mem <= 1'b1;
            end
          end
        end
        READ: begin
          r_data      <= DataOut;
          r_state     <= WRITE;
          r_read_mem  <= 1'b0;
          r_write_mem <= 1'b1;
        end
        WRITE: begin
          r_rem <= r_rem - C_LEN_ONE;
          if (r_rem == C_LEN_ONE) begin
            r_state     <= DONE;
            r_write_mem <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
          end else if (r_mode == COPY) begin
            r_state     <= READ;
            r_write_mem <= 1'b0;
            r_read_mem  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Address and write data are pure decodes of registered state, so they are
  // zero outside READ/WRITE without extra output registers.
  always_comb begin
    DataAddress = '0;
    DataIn      = '0;
    case (r_state)
      READ: begin
        DataAddress = w_src;
      end
      WRITE: begin
        DataAddress = w_dst;
        DataIn      = (r_mode == FILL) ? r_fill : r_data;
      end
      default: begin
        DataAddress = '0;
      end
    endcase
  end

  assign ReadMem  = r_read_mem;
  assign WriteMem = r_write_mem;
  assign Busy     = r_busy;
  assign Done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_mem_copy_engine.sv
// ============================================================================
// tb_mem_copy_engine : randomized and directed checks against a memory model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_mem_copy_engine;

  logic       CLK = 1'b0;
  logic       ResetN = 1'b0;
  logic       Start = 1'b0;
  logic       Mode = 1'b0;
  logic       Descend = 1'b0;
  logic [7:0] SrcAddr = 8'h00;
  logic [7:0] DstAddr = 8'h00;
  logic [7:0] Length = 8'h00;
  logic [7:0] FillValue = 8'h00;
  logic [7:0] DataAddress;
  logic       ReadMem;
  logic       WriteMem;
  logic [7:0] DataIn;
  wire  [7:0] DataOut;
  logic       Busy;
  logic       Done;

  logic [7:0] mem     [256];
  logic [7:0] exp_mem [256];

  int n_vec = 0;
  int n_bad = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int both_cnt = 0;
  int busy_cnt = 0;

  mem_copy_engine dut (
    .CLK         (CLK),
    .ResetN      (ResetN),
    .Start       (Start),
    .Mode        (Mode),
    .Descend     (Descend),
    .SrcAddr     (SrcAddr),
    .DstAddr     (DstAddr),
    .Length      (Length),
    .FillValue   (FillValue),
    .DataAddress (DataAddress),
    .ReadMem     (ReadMem),
    .WriteMem    (WriteMem),
    .DataIn      (DataIn),
    .DataOut     (DataOut),
    .Busy        (Busy),
    .Done        (Done)
  );

  always #5 CLK = ~CLK;

  assign DataOut = (ReadMem === 1'b1) ? mem[DataAddress] : 8'hzz;

  always @(posedge CLK) begin
    if (WriteMem === 1'b1) mem[DataAddress] <= DataIn;
  end

  always @(negedge CLK) begin
    if (ReadMem === 1'b1) rd_cnt++;
    if (WriteMem === 1'b1) wr_cnt++;
    if (ReadMem === 1'b1 && WriteMem === 1'b1) both_cnt++;
    if (Busy === 1'b1) busy_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // Reference: byte-at-a-time transfer in issue order, modulo-256 addresses.
  function automatic void model_op(input bit mode, input bit desc, input logic [7:0] src,
                                   input logic [7:0] dst, input int len, input logic [7:0] fill);
    logic [7:0] s, d;
    for (int i = 0; i < len; i++) begin
      s = 8'(int'(src) + (desc ? -i : i));
      d = 8'(int'(dst) + (desc ? -i : i));
      exp_mem[d] = mode ? fill : exp_mem[s];
    end
  endfunction

  function automatic int exp_latency(input bit mode, input int len);
    if (len == 0) return 1;
    return mode ? len + 1 : 2 * len + 1;
  endfunction

  function automatic int mem_diff();
    int n = 0;
    for (int a = 0; a < 256; a++) if (mem[a] !== exp_mem[a]) n++;
    return n;
  endfunction

  task automatic clear_counts();
    rd_cnt = 0; wr_cnt = 0; both_cnt = 0; busy_cnt = 0;
  endtask

  // Presents a one-cycle Start; returns #1 after the edge that samples it,
  // with the operand inputs scrambled to show they are not re-sampled.
  task automatic launch(input bit mode, input bit desc, input logic [7:0] src,
                        input logic [7:0] dst, input logic [7:0] len, input logic [7:0] fill);
    @(posedge CLK); #1;
    Start = 1'b1; Mode = mode; Descend = desc;
    SrcAddr = src; DstAddr = dst; Length = len; FillValue = fill;
    @(posedge CLK); #1;
    Start = 1'b0; Mode = $urandom; Descend = $urandom;
    SrcAddr = $urandom; DstAddr = $urandom; Length = $urandom; FillValue = $urandom;
  endtask

  task automatic wait_done(input int c0, output int cyc);
    cyc = c0;
    while (Done !== 1'b1 && cyc < 600) begin
      @(posedge CLK); #1;
      cyc++;
    end
  endtask

  task automatic exec(input bit mode, input bit desc, input logic [7:0] src, input logic [7:0] dst,
                      input logic [7:0] len, input logic [7:0] fill, output int cyc, output int diff);
    model_op(mode, desc, src, dst, int'(len), fill);
    clear_counts();
    launch(mode, desc, src, dst, len, fill);
    wait_done(1, cyc);
    diff = mem_diff();
  endtask

  task automatic test_reset();
    ResetN = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    n_vec++;
    if ({Busy, Done, ReadMem, WriteMem} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_ctrl: got %b, required 0000", {Busy, Done, ReadMem, WriteMem});
    end
    n_vec++;
    if ({DataAddress, DataIn} !== 16'h0000) begin
      n_bad++; $display("FAIL reset_bus: got %h, required 0000", {DataAddress, DataIn});
    end
    ResetN = 1'b1;
  endtask

  task automatic test_copy_basic();
    int cyc, diff;
    mem[8'h10] = 8'h11; mem[8'h11] = 8'h22; mem[8'h12] = 8'h33; mem[8'h13] = 8'h44;
    exp_mem = mem;
    exec(1'b0, 1'b0, 8'h10, 8'h80, 8'd4, 8'h00, cyc, diff);
    n_vec++;
    if (cyc !== 9) begin n_bad++; $display("FAIL copy_latency: got %0d, required 9", cyc); end
    n_vec++;
    if (diff !== 0) begin n_bad++; $display("FAIL copy_mem: got %0d bad bytes, required 0", diff); end
    n_vec++;
    if (mem[8'h83] !== 8'h44) begin n_bad++; $display("FAIL copy_last: got %h, required 44", mem[8'h83]); end
    n_vec++;
    if (rd_cnt !== 4 || wr_cnt !== 4 || both_cnt !== 0) begin
      n_bad++; $display("FAIL copy_pulses: got rd=%0d wr=%0d both=%0d, required 4 4 0", rd_cnt, wr_cnt, both_cnt);
    end
    n_vec++;
    if ({Busy, ReadMem, WriteMem, DataAddress} !== 11'd0) begin
      n_bad++; $display("FAIL done_outputs: got %h, required 000", {Busy, ReadMem, WriteMem, DataAddress});
    end
    @(posedge CLK); #1;
    n_vec++;
    if (Done !== 1'b0) begin n_bad++; $display("FAIL done_pulse: got %b one cycle later, required 0", Done); end
  endtask

  task automatic test_fill_wrap();
    int cyc, diff;
    exp_mem = mem;
    exec(1'b1, 1'b0, 8'h33, 8'hFE, 8'd4, 8'hA5, cyc, diff);
    n_vec++;
    if (cyc !== 5) begin n_bad++; $display("FAIL fill_latency: got %0d, required 5", cyc); end
    n_vec++;
    if (diff !== 0 || mem[8'h00] !== 8'hA5 || mem[8'h01] !== 8'hA5) begin
      n_bad++; $display("FAIL fill_wrap: got %0d bad bytes mem[0]=%h mem[1]=%h, required 0 A5 A5", diff, mem[8'h00], mem[8'h01]);
    end
    n_vec++;
    if (rd_cnt !== 0 || wr_cnt !== 4 || busy_cnt !== 4) begin
      n_bad++; $display("FAIL fill_pulses: got rd=%0d wr=%0d busy=%0d, required 0 4 4", rd_cnt, wr_cnt, busy_cnt);
    end
  endtask

  task automatic test_descend();
    int cyc, diff;
    for (int i = 0; i < 4; i++) mem[8'h20 + i] = 8'(i + 1);
    exp_mem = mem;
    exec(1'b0, 1'b1, 8'h23, 8'h24, 8'd4, 8'h00, cyc, diff);
    n_vec++;
    if (diff !== 0 || mem[8'h21] !== 8'd1 || mem[8'h24] !== 8'd4) begin
      n_bad++; $display("FAIL descend_mem: got %0d bad bytes [21]=%h [24]=%h, required 0 01 04", diff, mem[8'h21], mem[8'h24]);
    end
    n_vec++;
    if (cyc !== 9) begin n_bad++; $display("FAIL descend_latency: got %0d, required 9", cyc); end
  endtask

  task automatic test_zero_len();
    int cyc, diff;
    exp_mem = mem;
    exec(1'b0, 1'b0, 8'h05, 8'h90, 8'd0, 8'h00, cyc, diff);
    n_vec++;
    if (cyc !== 1) begin n_bad++; $display("FAIL zero_latency: got %0d, required 1", cyc); end
    n_vec++;
    if (rd_cnt !== 0 || wr_cnt !== 0 || diff !== 0) begin
      n_bad++; $display("FAIL zero_access: got rd=%0d wr=%0d diff=%0d, required 0 0 0", rd_cnt, wr_cnt, diff);
    end
  endtask

  task automatic test_ignore_start();
    int cyc, diff;
    exp_mem = mem;
    model_op(1'b0, 1'b0, 8'h40, 8'hC0, 6, 8'h00);
    clear_counts();
    launch(1'b0, 1'b0, 8'h40, 8'hC0, 8'd6, 8'h00);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    Start = 1'b1; Mode = 1'b1; DstAddr = 8'h41; Length = 8'd3; FillValue = 8'h5A;
    @(posedge CLK); #1;
    Start = 1'b0;
    wait_done(4, cyc);
    diff = mem_diff();
    n_vec++;
    if (cyc !== 13 || diff !== 0) begin
      n_bad++; $display("FAIL ignore_start: got latency=%0d diff=%0d, required 13 0", cyc, diff);
    end
  endtask

  task automatic test_abort_reset();
    int cyc, diff;
    exp_mem = mem;
    model_op(1'b0, 1'b0, 8'h50, 8'hB0, 2, 8'h00);
    clear_counts();
    launch(1'b0, 1'b0, 8'h50, 8'hB0, 8'd8, 8'h00);
    repeat (4) @(posedge CLK);
    #1;
    ResetN = 1'b0;
    @(posedge CLK); #1;
    diff = mem_diff();
    n_vec++;
    if (wr_cnt !== 2 || diff !== 0) begin
      n_bad++; $display("FAIL abort_writes: got wr=%0d diff=%0d, required 2 0", wr_cnt, diff);
    end
    n_vec++;
    if ({Busy, Done, ReadMem, WriteMem} !== 4'b0000) begin
      n_bad++; $display("FAIL abort_idle: got %b, required 0000", {Busy, Done, ReadMem, WriteMem});
    end
    ResetN = 1'b1;
    exec(1'b1, 1'b1, 8'h00, 8'h02, 8'd3, 8'h3C, cyc, diff);
    n_vec++;
    if (cyc !== 4 || diff !== 0) begin
      n_bad++; $display("FAIL restart: got latency=%0d diff=%0d, required 4 0", cyc, diff);
    end
  endtask

  task automatic test_random();
    int cyc, diff, len, ecyc;
    bit mode, desc;
    logic [7:0] src, dst, fill;
    for (int k = 0; k < 10; k++) begin
      mode = 1'($urandom); desc = 1'($urandom);
      src = 8'($urandom); dst = 8'($urandom); fill = 8'($urandom);
      len = $urandom_range(0, 24);
      exp_mem = mem;
      ecyc = exp_latency(mode, len);
      exec(mode, desc, src, dst, 8'(len), fill, cyc, diff);
      n_vec++;
      if (cyc !== ecyc || diff !== 0) begin
        n_bad++; $display("FAIL rand%0d_result: got latency=%0d diff=%0d, required %0d 0", k, cyc, diff, ecyc);
      end
      n_vec++;
      if (rd_cnt !== (mode ? 0 : len) || wr_cnt !== len || both_cnt !== 0 || busy_cnt !== ecyc - 1) begin
        n_bad++; $display("FAIL rand%0d_pulses: got rd=%0d wr=%0d both=%0d busy=%0d, required %0d %0d 0 %0d",
                          k, rd_cnt, wr_cnt, both_cnt, busy_cnt, mode ? 0 : len, len, ecyc - 1);
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
    test_reset();
    test_copy_basic();
    test_fill_wrap();
    test_descend();
    test_zero_len();
    test_ignore_start();
    test_abort_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
